// File: rtl/asmd_multiplier_signed.sv
// Sequential shift-add multiplier with per-operation unsigned/signed mode.
// Operates on operand magnitudes, applies the sign at the end, and exits early on a zero operand.
module asmd_multiplier_signed #(
    parameter int word_length = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       signed_mode,
    input  logic [word_length-1:0]     word0,
    input  logic [word_length-1:0]     word1,
    output logic [2*word_length-1:0]   product,
    output logic                       ready,
    output logic                       done
);

    localparam int W     = word_length;
    localparam int CNT_W = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2
    } state_t;

    // W bits hold every magnitude, including 2^(W-1) for the most negative input.
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] value, input logic is_signed);
        if (is_signed && value[W-1]) begin
            return -value;
        end else begin
            return value;
        end
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic [W-1:0]       mcand_r;
    logic [2*W-1:0]     acc_r;
    logic [CNT_W-1:0]   count_r;
    logic               neg_r;
    logic [2*W-1:0]     product_r;
    logic               ready_r;
    logic               done_r;

    logic [W-1:0]       mag0_s;
    logic [W-1:0]       mag1_s;
    logic               zero_s;
    logic [W-1:0]       addend_s;
    logic [W:0]         sum_s;

    // Next-state decode plus operand magnitudes and the shift-add step.
    always_comb begin
        state_next_s = state_r;
        mag0_s       = magnitude(word0, signed_mode);
        mag1_s       = magnitude(word1, signed_mode);
        zero_s       = (mag0_s == {W{1'b0}}) || (mag1_s == {W{1'b0}});
        if (acc_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = {W{1'b0}};
        end
        sum_s = {1'b0, acc_r[2*W-1:W]} + {1'b0, addend_s};
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = zero_s ? SIGN : RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (count_r == CNT_W'(W - 1)) begin
                    state_next_s = SIGN;
                end else begin
                    state_next_s = RUN;
                end
            end
            SIGN:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath and registered outputs; acc holds {upper partial sum, remaining multiplier bits}.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand_r   <= {W{1'b0}};
            acc_r     <= {(2*W){1'b0}};
            count_r   <= {CNT_W{1'b0}};
            neg_r     <= 1'b0;
            product_r <= {(2*W){1'b0}};
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
        end else begin
            ready_r <= (state_next_s == IDLE);
            done_r  <= (state_r == SIGN);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mcand_r <= mag0_s;
                        acc_r   <= zero_s ? {(2*W){1'b0}} : {{W{1'b0}}, mag1_s};
                        neg_r   <= signed_mode & (word0[W-1] ^ word1[W-1]);
                        count_r <= {CNT_W{1'b0}};
                    end
                end
                RUN: begin
                    acc_r   <= {sum_s, acc_r[W-1:1]};
                    count_r <= count_r + CNT_W'(1);
                end
                SIGN: begin
                    product_r <= neg_r ? (-acc_r) : acc_r;
                end
                default: begin
                    mcand_r <= {W{1'b0}};
                end
            endcase
        end
    end

    assign product = product_r;
    assign ready   = ready_r;
    assign done    = done_r;

endmodule

// File: tb/tb_asmd_multiplier_signed.sv
// Randomised self-checking bench for asmd_multiplier_signed at W=4 and W=8 against an integer reference model.
module tb_asmd_multiplier_signed;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start4, sm4, ready4, done4;
    logic [3:0]  a4, b4;
    logic [7:0]  prod4;
    logic        start8, sm8, ready8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    asmd_multiplier_signed #(.word_length(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .signed_mode(sm4),
        .word0(a4), .word1(b4), .product(prod4), .ready(ready4), .done(done4)
    );

    asmd_multiplier_signed #(.word_length(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
        .word0(a8), .word1(b8), .product(prod8), .ready(ready8), .done(done8)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] obs_prod(input int w);
        return (w == 4) ? {8'h00, prod4} : prod8;
    endfunction

    function automatic logic obs_ready(input int w);
        return (w == 4) ? ready4 : ready8;
    endfunction

    function automatic logic obs_done(input int w);
        return (w == 4) ? done4 : done8;
    endfunction

    task automatic drive(input int w, input logic st, input logic s, input logic [7:0] a, input logic [7:0] b);
        if (w == 4) begin
            start4 = st; sm4 = s; a4 = a[3:0]; b4 = b[3:0];
        end else begin
            start8 = st; sm8 = s; a8 = a; b8 = b;
        end
    endtask

    // Reference: interpret operands as integers and keep the low 2W bits of the true product.
    function automatic logic [15:0] model(input int w, input logic [7:0] a, input logic [7:0] b, input logic sm);
        longint m, va, vb, p;
        m  = (longint'(1) << w) - 1;
        va = longint'(a) & m;
        vb = longint'(b) & m;
        if (sm && va >= (longint'(1) << (w - 1))) va = va - (longint'(1) << w);
        if (sm && vb >= (longint'(1) << (w - 1))) vb = vb - (longint'(1) << w);
        p = va * vb;
        return 16'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic sm,
                          input bit hold, input bit scramble);
        logic [15:0] exp_prod, prev;
        longint      m;
        int          lat, exp_lat;
        bit          seen;
        m        = (longint'(1) << w) - 1;
        exp_prod = model(w, a, b, sm);
        exp_lat  = ((longint'(a) & m) == 0 || (longint'(b) & m) == 0) ? 1 : w + 1;
        prev     = obs_prod(w);
        checks++;
        if (obs_ready(w) !== 1'b1)
            $display("FAIL ready_before w=%0d got=%b want=1", w, obs_ready(w));
        if (obs_ready(w) !== 1'b1) errors++;
        drive(w, 1'b1, sm, a, b);
        tick;
        lat  = 0;
        seen = 0;
        if (!hold) drive(w, 1'b0, sm, a, b);
        while (!seen && lat <= 20) begin
            if (obs_done(w) === 1'b1) begin
                seen = 1;
            end else begin
                checks++;
                if (obs_ready(w) !== 1'b0 || obs_prod(w) !== prev) begin
                    errors++;
                    $display("FAIL busy w=%0d cyc=%0d ready=%b prod=%h want ready=0 prod=%h",
                             w, lat, obs_ready(w), obs_prod(w), prev);
                end
                if (scramble)
                    drive(w, hold ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          8'($urandom), 8'($urandom));
                tick;
                lat++;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout w=%0d a=%h b=%h no done within %0d cycles", w, a, b, lat);
            drive(w, 1'b0, sm, a, b);
            return;
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL latency w=%0d a=%h b=%h got=%0d want=%0d", w, a, b, lat, exp_lat);
        end
        checks++;
        if (obs_prod(w) !== exp_prod) begin
            errors++;
            $display("FAIL product w=%0d sm=%b a=%h b=%h got=%h want=%h", w, sm, a, b, obs_prod(w), exp_prod);
        end
        checks++;
        if (obs_ready(w) !== 1'b1) begin
            errors++;
            $display("FAIL ready_at_done w=%0d got=%b want=1", w, obs_ready(w));
        end
        if (!hold) begin
            drive(w, 1'b0, sm, a, b);
            tick;
            checks++;
            if (obs_done(w) !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse w=%0d got=%b want=0", w, obs_done(w));
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        tick;
        checks++;
        if (prod4 !== 8'h00 || ready4 !== 1'b1 || done4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_w4 prod=%h ready=%b done=%b want 00/1/0", prod4, ready4, done4);
        end
        checks++;
        if (prod8 !== 16'h0000 || ready8 !== 1'b1 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_w8 prod=%h ready=%b done=%b want 0000/1/0", prod8, ready8, done8);
        end
    endtask

    task automatic test_unsigned;
        run_op(4, 8'h04, 8'h05, 1'b0, 1'b0, 1'b0);
        run_op(4, 8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_signed;
        run_op(4, 8'h0D, 8'h05, 1'b1, 1'b0, 1'b0);
        run_op(4, 8'h08, 8'h08, 1'b1, 1'b0, 1'b0);
        run_op(4, 8'h08, 8'h07, 1'b1, 1'b0, 1'b0);
        run_op(8, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0);
        run_op(8, 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_mode;
        run_op(4, 8'h0D, 8'h05, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_early_exit;
        run_op(8, 8'h07, 8'h09, 1'b0, 1'b0, 1'b0);
        run_op(8, 8'h00, 8'h9A, 1'b0, 1'b0, 1'b0);
        run_op(8, 8'h33, 8'h44, 1'b1, 1'b0, 1'b0);
        run_op(8, 8'hC5, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_run;
        bit pulsed;
        run_op(8, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
        drive(8, 1'b1, 1'b0, 8'hC8, 8'h64);
        tick;
        drive(8, 1'b0, 1'b0, 8'hC8, 8'h64);
        tick;
        tick;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (ready8 !== 1'b1 || prod8 !== 16'h0000 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run ready=%b prod=%h done=%b want 1/0000/0", ready8, prod8, done8);
        end
        pulsed = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done8 === 1'b1) pulsed = 1;
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (done8 === 1'b1) pulsed = 1;
        end
        checks++;
        if (pulsed || ready8 !== 1'b1) begin
            errors++;
            $display("FAIL reset_no_done pulsed=%b ready=%b want 0/1", pulsed, ready8);
        end
    endtask

    task automatic test_ignore;
        run_op(8, 8'hA7, 8'h3C, 1'b0, 1'b0, 1'b1);
        run_op(8, 8'hA7, 8'h3C, 1'b1, 1'b0, 1'b1);
        run_op(4, 8'h0B, 8'h06, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back;
        run_op(8, 8'h11, 8'h22, 1'b0, 1'b1, 1'b0);
        run_op(8, 8'hF0, 8'h0F, 1'b1, 1'b1, 1'b0);
        run_op(8, 8'h00, 8'h55, 1'b0, 1'b1, 1'b0);
        run_op(8, 8'h7B, 8'hE3, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_max;
        run_op(8, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
        run_op(4, 8'h0F, 8'h0F, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        logic [7:0] a, b;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 7) == 0) a = 8'h00;
            if ($urandom_range(0, 7) == 0) b = 8'h80;
            run_op((i % 2 == 0) ? 8 : 4, a, b, 1'($urandom_range(0, 1)), 1'b0, (i % 3) == 0);
        end
    endtask

    initial begin
        drive(4, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(8, 1'b0, 1'b0, 8'h00, 8'h00);
        test_reset;
        test_unsigned;
        test_signed;
        test_mode;
        test_early_exit;
        test_reset_mid_run;
        test_ignore;
        test_back_to_back;
        test_max;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/asmd_multiplier_signed.md
Name: asmd_multiplier_signed

Overview:
- Next-generation sequential shift-add (ASMD) multiplier.
- Parametrised word length; per-operation unsigned/signed (two's complement) mode; zero-operand early termination; one-cycle done pulse.
- Used as a multi-cycle arithmetic unit behind a start/ready handshake. It is a drop-in successor to the fixed unsigned multiplier, with the extra mode input and done output.

Parameters:
- word_length, 8, operand width W in bits; must be >= 2. Product width is 2W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request; sampled only while ready=1.
- signed_mode  input  1  1 = operands and product are two's complement; 0 = unsigned. Latched with start.
- word0  input  W  multiplicand; latched with start.
- word1  input  W  multiplier; latched with start.
- product  output  2W  registered result; holds the last completed result.
- ready  output  1  1 = idle, able to accept start.
- done  output  1  one-cycle pulse coincident with the product update.

Behaviour:
- Reset (reset=0, async): state=IDLE, product=0, ready=1, done=0, all internal registers cleared. Takes effect immediately, including mid-operation; the partial result is discarded.
- States: IDLE, RUN, SIGN.
- IDLE:
  - ready=1.
  - On a clock edge with start=1, latch the operands and mode:
    - Magnitudes: in signed mode, a negative operand is negated; the MSB-set value -2^(W-1) yields the unsigned magnitude 2^(W-1).
    - neg = signed_mode & (word0[W-1] ^ word1[W-1]).
    - acc=0, count=0.
  - If either latched magnitude is 0, go to SIGN (early exit); otherwise go to RUN.
  - With start=0, stay in IDLE.
- RUN:
  - ready=0.
  - Each cycle: if the multiplier LSB is 1, the upper accumulator half += multiplicand magnitude, carry kept in a (W+1)-bit sum. Then shift {carry, acc, multiplier} right by 1.
  - count increments each cycle. After exactly W RUN cycles, go to SIGN.
- SIGN:
  - ready=0.
  - On the next edge: product = neg ? -acc : acc (2W-bit two's complement), done=1 for exactly one cycle, go to IDLE.
- Latency, counted from the start-sampling edge E0:
  - Normal operation: product, done=1 and ready=1 all appear after edge E(W+1). ready is low for W+1 cycles.
  - Early exit: product=0 and done appear after E1. ready is low for 1 cycle.
- product is stable between completions. It does not change at start or during RUN/SIGN.
- start while ready=0 is ignored; no queuing. start held high continuously starts a new operation on the first IDLE edge after done, i.e. back-to-back operation with no gap cycle beyond IDLE.
- Changes to word0, word1 or signed_mode after E0 have no effect on the current operation.
- Range: the result is always exact in 2W bits.
  - Unsigned max: (2^W-1)^2.
  - Signed extremes: (-2^(W-1))^2 = 2^(2W-2) and -2^(W-1)*(2^(W-1)-1). Both are representable, so there is no overflow condition.
- done and ready are registered outputs; there is no combinational path from the inputs to the outputs.

Test Plan:
- Reset: W=4, hold reset=0 for 2 cycles, release -> product=8'h00, ready=1, done=0. Assert reset=0 mid-RUN -> ready=1 and product=0 immediately, with no done pulse.
- Unsigned, W=4, signed_mode=0: 4*5 -> product=20 (8'h14), ready low 5 cycles, done pulse at E5. Then 15*15 -> 225 (8'hE1).
- Signed, W=4, signed_mode=1:
  - 4'hD(-3) * 4'h5 -> 8'hF1 (-15).
  - 4'h8(-8) * 4'h8(-8) -> 8'h40 (64).
  - 4'h8(-8) * 4'h7 -> 8'hC8 (-56).
- Same bits, other mode: 4'hD * 4'h5 with signed_mode=0 -> 8'h41 (65).
- Early exit, W=8: 0 * 8'h9A -> product=0, ready low exactly 1 cycle, done pulse at E1. A previous nonzero product is held until E1.
- Handshake:
  - Toggle start and operands during RUN -> ignored, result unchanged.
  - start held high across 3 operations -> 3 done pulses, each result correct.
  - W=8, 255*255 -> 16'hFE01 with ready low 9 cycles.
